// File: rtl/bp_stream_host_responder_if.sv
// rtl/bp_stream_host_responder_if.sv - word-stream and target-port bundle for bp_stream_host_responder
interface bp_stream_host_responder_if #(
  parameter int stream_data_width_p = 32,
  parameter int data_width_p        = 64,
  parameter int addr_width_p        = 30
);
  logic                           stream_v_i;
  logic [stream_data_width_p-1:0] stream_data_i;
  logic                           stream_ready_o;
  logic                           stream_v_o;
  logic [stream_data_width_p-1:0] stream_data_o;
  logic                           stream_yumi_i;
  logic                           mem_v_o;
  logic                           mem_w_o;
  logic [addr_width_p-1:0]        mem_addr_o;
  logic [stream_data_width_p-1:0] mem_data_o;
  logic                           mem_ready_i;
  logic                           mem_v_i;
  logic [data_width_p-1:0]        mem_data_i;

  // slave is the responder itself; master is the link/target side driving it
  modport slave (
    input  stream_v_i, stream_data_i, stream_yumi_i, mem_ready_i, mem_v_i, mem_data_i,
    output stream_ready_o, stream_v_o, stream_data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o
  );

  modport master (
    output stream_v_i, stream_data_i, stream_yumi_i, mem_ready_i, mem_v_i, mem_data_i,
    input  stream_ready_o, stream_v_o, stream_data_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/bp_stream_host_responder.sv
// rtl/bp_stream_host_responder.sv - host-side MMIO responder for the BlackParrot word stream
// Optional read timeout enabled by defining BP_STREAM_HOST_RD_TIMEOUT_EN.
module bp_stream_host_responder #(
  parameter int stream_data_width_p = 32,
  parameter int data_width_p        = 64,
  parameter int addr_width_p        = 30,
  parameter int timeout_cycles_p    = 1024
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  bp_stream_host_responder_if.slave    bus
);
  localparam int W     = stream_data_width_p;
  localparam int ELS   = data_width_p / stream_data_width_p;
  localparam int CNT_W = (ELS > 1) ? $clog2(ELS) : 1;

  typedef enum logic [2:0] {ADDR, DATA, ISSUE, WAIT_RD, SEND} state_e;

  state_e                    state_r, state_n;
  logic [1:0]                op_r, op_n;
  logic [addr_width_p-1:0]   addr_r, addr_n;
  logic [W-1:0]              wdata_r, wdata_n;
  logic [data_width_p-1:0]   shift_r, shift_n;
  logic [CNT_W-1:0]          cnt_r, cnt_n;

`ifdef BP_STREAM_HOST_RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(timeout_cycles_p + 1);
  localparam int REPS  = (data_width_p + 31) / 32;
  localparam logic [REPS*32-1:0] DEAD_REP = {REPS{32'hDEADBEEF}};
  logic [TMO_W-1:0] tmo_r, tmo_n;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= ADDR;
      op_r    <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      shift_r <= '0;
      cnt_r   <= '0;
`ifdef BP_STREAM_HOST_RD_TIMEOUT_EN
      tmo_r   <= '0;
`endif
    end else begin
      state_r <= state_n;
      op_r    <= op_n;
      addr_r  <= addr_n;
      wdata_r <= wdata_n;
      shift_r <= shift_n;
      cnt_r   <= cnt_n;
`ifdef BP_STREAM_HOST_RD_TIMEOUT_EN
      tmo_r   <= tmo_n;
`endif
    end
  end

  always_comb begin
    state_n = state_r;
    op_n    = op_r;
    addr_n  = addr_r;
    wdata_n = wdata_r;
    shift_n = shift_r;
    cnt_n   = cnt_r;
`ifdef BP_STREAM_HOST_RD_TIMEOUT_EN
    tmo_n   = '0;
`endif
    case (state_r)
      ADDR: if (bus.stream_v_i) begin
        op_n    = bus.stream_data_i[W-1 -: 2];
        addr_n  = bus.stream_data_i[addr_width_p-1:0];
        state_n = DATA;
      end
      DATA: if (bus.stream_v_i) begin
        wdata_n = bus.stream_data_i;
        // reserved ops still consume the data word so framing stays aligned
        state_n = op_r[1] ? ADDR : ISSUE;
      end
      ISSUE: if (bus.mem_ready_i) begin
        state_n = op_r[0] ? ADDR : WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.mem_v_i) begin
          shift_n = bus.mem_data_i;
          cnt_n   = '0;
          state_n = SEND;
        end
`ifdef BP_STREAM_HOST_RD_TIMEOUT_EN
        else if (tmo_r == TMO_W'(timeout_cycles_p - 1)) begin
          shift_n = DEAD_REP[data_width_p-1:0];
          cnt_n   = '0;
          state_n = SEND;
        end else begin
          tmo_n = tmo_r + 1'b1;
        end
`endif
      end
      SEND: if (bus.stream_yumi_i) begin
        shift_n = shift_r >> W;
        cnt_n   = cnt_r + 1'b1;
        if (cnt_r == CNT_W'(ELS - 1)) state_n = ADDR;
      end
      default: state_n = ADDR;
    endcase
  end

  assign bus.stream_ready_o = (state_r == ADDR) || (state_r == DATA);
  assign bus.stream_v_o     = (state_r == SEND);
  assign bus.stream_data_o  = shift_r[W-1:0];
  assign bus.mem_v_o        = (state_r == ISSUE);
  assign bus.mem_w_o        = (op_r == 2'b01);
  assign bus.mem_addr_o     = addr_r;
  assign bus.mem_data_o     = wdata_r;
endmodule

// File: tb/tb_bp_stream_host_responder.sv
// tb/tb_bp_stream_host_responder.sv - directed self-checking bench for bp_stream_host_responder
module tb_bp_stream_host_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bp_stream_host_responder_if #(.stream_data_width_p(32), .data_width_p(64), .addr_width_p(30)) bus ();

  bp_stream_host_responder #(
    .stream_data_width_p(32), .data_width_p(64), .addr_width_p(30), .timeout_cycles_p(16)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .bus(bus)
  );

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    bus.stream_v_i = 1'b1;
    bus.stream_data_i = w;
    while (!bus.stream_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (n >= 50) begin fails++; $display("FAIL push_ready got 0 want 1 (word %h)", w); end
    @(negedge clk);
    bus.stream_v_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.stream_v_i = 0; bus.stream_data_i = '0; bus.stream_yumi_i = 0;
    bus.mem_ready_i = 1; bus.mem_v_i = 0; bus.mem_data_i = '0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    vecs++; if (bus.stream_ready_o !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", bus.stream_ready_o); end
    vecs++; if (bus.stream_v_o !== 1'b0) begin fails++; $display("FAIL rst_stream_v got %b want 0", bus.stream_v_o); end
    vecs++; if ({bus.mem_v_o, bus.mem_w_o} !== 2'b00) begin fails++; $display("FAIL rst_mem_vw got %b want 00", {bus.mem_v_o, bus.mem_w_o}); end
    vecs++; if (bus.mem_addr_o !== 30'h0 || bus.mem_data_o !== 32'h0 || bus.stream_data_o !== 32'h0) begin
      fails++; $display("FAIL rst_data got %h/%h/%h want 0/0/0", bus.mem_addr_o, bus.mem_data_o, bus.stream_data_o); end
    rst_n = 1;
  endtask

  task automatic test_write();
    bus.mem_ready_i = 1;
    push_word(32'h4000_0010);
    push_word(32'hCAFE_F00D);
    vecs++; if ({bus.mem_v_o, bus.mem_w_o} !== 2'b11) begin fails++; $display("FAIL wr_mem_vw got %b want 11", {bus.mem_v_o, bus.mem_w_o}); end
    vecs++; if (bus.mem_addr_o !== 30'h10) begin fails++; $display("FAIL wr_addr got %h want 10", bus.mem_addr_o); end
    vecs++; if (bus.mem_data_o !== 32'hCAFEF00D) begin fails++; $display("FAIL wr_data got %h want cafef00d", bus.mem_data_o); end
    vecs++; if (bus.stream_ready_o !== 1'b0) begin fails++; $display("FAIL wr_issue_ready got %b want 0", bus.stream_ready_o); end
    @(negedge clk);
    vecs++; if (bus.mem_v_o !== 1'b0 || bus.stream_v_o !== 1'b0 || bus.stream_ready_o !== 1'b1) begin
      fails++; $display("FAIL wr_done got mv=%b sv=%b rdy=%b want 0 0 1", bus.mem_v_o, bus.stream_v_o, bus.stream_ready_o); end
  endtask

  task automatic test_read();
    bus.mem_ready_i = 1;
    push_word(32'h0000_0020);
    push_word(32'h0000_0000);
    vecs++; if ({bus.mem_v_o, bus.mem_w_o} !== 2'b10 || bus.mem_addr_o !== 30'h20) begin
      fails++; $display("FAIL rd_issue got vw=%b addr=%h want 10 20", {bus.mem_v_o, bus.mem_w_o}, bus.mem_addr_o); end
    @(negedge clk);
    vecs++; if (bus.mem_v_o !== 1'b0 || bus.stream_v_o !== 1'b0) begin fails++; $display("FAIL rd_wait got mv=%b sv=%b want 0 0", bus.mem_v_o, bus.stream_v_o); end
    bus.mem_v_i = 1; bus.mem_data_i = 64'h1122334455667788;
    @(negedge clk);
    bus.mem_v_i = 0;
    vecs++; if (bus.stream_v_o !== 1'b1 || bus.stream_data_o !== 32'h55667788) begin
      fails++; $display("FAIL rd_word0 got v=%b %h want 1 55667788", bus.stream_v_o, bus.stream_data_o); end
    bus.stream_yumi_i = 1;
    @(negedge clk);
    vecs++; if (bus.stream_v_o !== 1'b1 || bus.stream_data_o !== 32'h11223344) begin
      fails++; $display("FAIL rd_word1 got v=%b %h want 1 11223344", bus.stream_v_o, bus.stream_data_o); end
    @(negedge clk);
    bus.stream_yumi_i = 0;
    vecs++; if (bus.stream_v_o !== 1'b0 || bus.stream_ready_o !== 1'b1) begin
      fails++; $display("FAIL rd_done got sv=%b rdy=%b want 0 1", bus.stream_v_o, bus.stream_ready_o); end
  endtask

  task automatic test_backpressure();
    bus.mem_ready_i = 0;
    push_word(32'h0000_0030);
    push_word(32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      vecs++; if (bus.mem_v_o !== 1'b1 || bus.mem_w_o !== 1'b0 || bus.mem_addr_o !== 30'h30 || bus.stream_ready_o !== 1'b0) begin
        fails++; $display("FAIL bp_issue_hold[%0d] got v=%b w=%b addr=%h rdy=%b want 1 0 30 0", i, bus.mem_v_o, bus.mem_w_o, bus.mem_addr_o, bus.stream_ready_o); end
      if (i < 2) @(negedge clk);
    end
    bus.mem_ready_i = 1;
    @(negedge clk);
    vecs++; if (bus.mem_v_o !== 1'b0) begin fails++; $display("FAIL bp_accept got mv=%b want 0", bus.mem_v_o); end
    bus.mem_v_i = 1; bus.mem_data_i = 64'hAAAABBBB_CCCCDDDD;
    @(negedge clk);
    bus.mem_v_i = 0;
    for (int i = 0; i < 5; i++) begin
      vecs++; if (bus.stream_v_o !== 1'b1 || bus.stream_data_o !== 32'hCCCCDDDD || bus.stream_ready_o !== 1'b0) begin
        fails++; $display("FAIL bp_send_hold[%0d] got v=%b %h rdy=%b want 1 ccccdddd 0", i, bus.stream_v_o, bus.stream_data_o, bus.stream_ready_o); end
      @(negedge clk);
    end
    bus.stream_yumi_i = 1;
    @(negedge clk);
    vecs++; if (bus.stream_v_o !== 1'b1 || bus.stream_data_o !== 32'hAAAABBBB) begin
      fails++; $display("FAIL bp_word1 got v=%b %h want 1 aaaabbbb", bus.stream_v_o, bus.stream_data_o); end
    @(negedge clk);
    bus.stream_yumi_i = 0;
    vecs++; if (bus.stream_v_o !== 1'b0) begin fails++; $display("FAIL bp_done got sv=%b want 0", bus.stream_v_o); end
  endtask

  task automatic test_reserved();
    bus.mem_ready_i = 1;
    push_word(32'h8000_0004);
    push_word(32'h0000_0001);
    for (int i = 0; i < 4; i++) begin
      vecs++; if (bus.mem_v_o !== 1'b0 || bus.stream_v_o !== 1'b0 || bus.stream_ready_o !== 1'b1) begin
        fails++; $display("FAIL rsv_drop[%0d] got mv=%b sv=%b rdy=%b want 0 0 1", i, bus.mem_v_o, bus.stream_v_o, bus.stream_ready_o); end
      @(negedge clk);
    end
    push_word(32'h4000_0044);
    push_word(32'h1234_5678);
    vecs++; if ({bus.mem_v_o, bus.mem_w_o} !== 2'b11 || bus.mem_addr_o !== 30'h44 || bus.mem_data_o !== 32'h12345678) begin
      fails++; $display("FAIL rsv_next_wr got vw=%b addr=%h data=%h want 11 44 12345678", {bus.mem_v_o, bus.mem_w_o}, bus.mem_addr_o, bus.mem_data_o); end
    @(negedge clk);
    vecs++; if (bus.mem_v_o !== 1'b0 || bus.stream_v_o !== 1'b0) begin fails++; $display("FAIL rsv_next_done got mv=%b sv=%b want 0 0", bus.mem_v_o, bus.stream_v_o); end
  endtask

  task automatic test_same_cycle_rsp();
    bus.mem_ready_i = 1;
    bus.mem_v_i = 1; bus.mem_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    vecs++; if (bus.stream_v_o !== 1'b0) begin fails++; $display("FAIL idle_memv got sv=%b want 0", bus.stream_v_o); end
    bus.mem_v_i = 0;
    push_word(32'h0000_0028);
    push_word(32'h0000_0000);
    bus.mem_v_i = 1; bus.mem_data_i = 64'hDEAD_0000_0000_DEAD;
    @(negedge clk);
    bus.mem_v_i = 0;
    vecs++; if (bus.stream_v_o !== 1'b0 || bus.mem_v_o !== 1'b0) begin
      fails++; $display("FAIL same_cycle_ignored got sv=%b mv=%b want 0 0", bus.stream_v_o, bus.mem_v_o); end
    @(negedge clk);
    bus.mem_v_i = 1; bus.mem_data_i = 64'h0BAD_F00D_600D_CAFE;
    @(negedge clk);
    bus.mem_v_i = 0;
    vecs++; if (bus.stream_v_o !== 1'b1 || bus.stream_data_o !== 32'h600DCAFE) begin
      fails++; $display("FAIL same_cycle_word0 got v=%b %h want 1 600dcafe", bus.stream_v_o, bus.stream_data_o); end
    bus.stream_yumi_i = 1;
    @(negedge clk);
    vecs++; if (bus.stream_data_o !== 32'h0BADF00D) begin fails++; $display("FAIL same_cycle_word1 got %h want 0badf00d", bus.stream_data_o); end
    @(negedge clk);
    bus.stream_yumi_i = 0;
  endtask

  task automatic test_reset_mid_send();
    bus.mem_ready_i = 1;
    push_word(32'h0000_0008);
    push_word(32'h0000_0000);
    @(negedge clk);
    bus.mem_v_i = 1; bus.mem_data_i = 64'h01234567_89ABCDEF;
    @(negedge clk);
    bus.mem_v_i = 0;
    bus.stream_yumi_i = 1;
    @(negedge clk);
    bus.stream_yumi_i = 0;
    vecs++; if (bus.stream_data_o !== 32'h01234567) begin fails++; $display("FAIL rms_word1 got %h want 01234567", bus.stream_data_o); end
    rst_n = 0;
    #1;
    vecs++; if (bus.stream_v_o !== 1'b0 || bus.stream_ready_o !== 1'b1 || bus.stream_data_o !== 32'h0) begin
      fails++; $display("FAIL rms_async got sv=%b rdy=%b d=%h want 0 1 0", bus.stream_v_o, bus.stream_ready_o, bus.stream_data_o); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    vecs++; if (bus.stream_v_o !== 1'b0) begin fails++; $display("FAIL rms_quiet got sv=%b want 0", bus.stream_v_o); end
    push_word(32'h0000_0018);
    push_word(32'h0000_0000);
    vecs++; if (bus.mem_v_o !== 1'b1 || bus.mem_addr_o !== 30'h18) begin fails++; $display("FAIL rms_rd_issue got mv=%b addr=%h want 1 18", bus.mem_v_o, bus.mem_addr_o); end
    @(negedge clk);
    bus.mem_v_i = 1; bus.mem_data_i = 64'hFEDCBA98_76543210;
    @(negedge clk);
    bus.mem_v_i = 0;
    vecs++; if (bus.stream_v_o !== 1'b1 || bus.stream_data_o !== 32'h76543210) begin
      fails++; $display("FAIL rms_rd_word0 got v=%b %h want 1 76543210", bus.stream_v_o, bus.stream_data_o); end
    bus.stream_yumi_i = 1;
    @(negedge clk);
    vecs++; if (bus.stream_data_o !== 32'hFEDCBA98) begin fails++; $display("FAIL rms_rd_word1 got %h want fedcba98", bus.stream_data_o); end
    @(negedge clk);
    bus.stream_yumi_i = 0;
  endtask

`ifdef BP_STREAM_HOST_RD_TIMEOUT_EN
  task automatic test_timeout();
    bus.mem_ready_i = 1;
    push_word(32'h0000_0040);
    push_word(32'h0000_0000);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      vecs++; if (bus.stream_v_o !== 1'b0) begin fails++; $display("FAIL tmo_wait[%0d] got sv=%b want 0", i, bus.stream_v_o); end
      @(negedge clk);
    end
    vecs++; if (bus.stream_v_o !== 1'b1 || bus.stream_data_o !== 32'hDEADBEEF) begin
      fails++; $display("FAIL tmo_word0 got v=%b %h want 1 deadbeef", bus.stream_v_o, bus.stream_data_o); end
    bus.mem_v_i = 1; bus.mem_data_i = 64'h1111_2222_3333_4444;
    @(negedge clk);
    bus.mem_v_i = 0;
    bus.stream_yumi_i = 1;
    @(negedge clk);
    vecs++; if (bus.stream_v_o !== 1'b1 || bus.stream_data_o !== 32'hDEADBEEF) begin
      fails++; $display("FAIL tmo_word1 got v=%b %h want 1 deadbeef", bus.stream_v_o, bus.stream_data_o); end
    @(negedge clk);
    bus.stream_yumi_i = 0;
    vecs++; if (bus.stream_v_o !== 1'b0 || bus.stream_ready_o !== 1'b1) begin
      fails++; $display("FAIL tmo_done got sv=%b rdy=%b want 0 1", bus.stream_v_o, bus.stream_ready_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_reserved();
    test_same_cycle_rsp();
    test_reset_mid_send();
`ifdef BP_STREAM_HOST_RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
